// File: rtl/axis_adc_decimator.sv
// Boxcar-averaging decimator for packed multi-lane ADC words. Every 2^L samples it emits
// one sign-extended average per lane on an AXI-Stream master. A result that cannot be held is dropped and flagged.
//
// state | meaning
// IDLE  | averaging disabled; accumulators and sample counter held at zero
// ACCUM | averaging enabled; each valid sample is summed into its lane accumulator
module axis_adc_decimator #(
  parameter int INT_ADC_CHANNELS    = 2,
  parameter int INT_ADC_DATA_WIDTH  = 10,
  parameter int INT_AXIS_DATA_WIDTH = 32,
  parameter int INT_LOG2_DECIMATION = 4
) (
  input  logic                           in_adc_clk,
  input  logic                           in_rst,
  input  logic                           in_enable,
  input  logic                           in_clear_overflow,
  input  logic                           s_axis_valid,
  input  logic [INT_AXIS_DATA_WIDTH-1:0] s_axis_data,
  output logic                           m_axis_valid,
  input  logic                           m_axis_ready,
  output logic [INT_AXIS_DATA_WIDTH-1:0] m_axis_data,
  output logic                           out_overflow,
  output logic [15:0]                    out_block_count
);

  localparam int CH    = INT_ADC_CHANNELS;
  localparam int D     = INT_ADC_DATA_WIDTH;
  localparam int AXW   = INT_AXIS_DATA_WIDTH;
  localparam int L     = INT_LOG2_DECIMATION;
  localparam int W     = AXW / CH;
  localparam int ACC_W = D + L;
  localparam int CNT_W = (L > 0) ? L : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << L) - 1);

  if (CH < 1 || CH > 2) begin : g_bad_channels
    $error("axis_adc_decimator: INT_ADC_CHANNELS must be 1 or 2");
  end
  if ((AXW % CH) != 0 || W <= D) begin : g_bad_width
    $error("axis_adc_decimator: lane width must divide the stream and exceed the sample width");
  end
  if (L < 0 || L > 8) begin : g_bad_log2
    $error("axis_adc_decimator: INT_LOG2_DECIMATION must be in 0..8");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t state, state_next;

  logic                    accept;
  logic                    done;
  logic                    load;
  logic                    drop;
  logic [CNT_W-1:0]        count;
  logic signed [D-1:0]     sample [CH];
  logic signed [ACC_W-1:0] acc    [CH];
  logic signed [ACC_W-1:0] sum    [CH];
  logic signed [D-1:0]     avg    [CH];
  logic [AXW-1:0]          result_word;

  // Padding bits between lanes carry no information.
  logic unused_pad;
  assign unused_pad = ^s_axis_data;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_enable) begin
          state_next = ACCUM;
          accept     = s_axis_valid;
        end
      end
      ACCUM: begin
        if (!in_enable) begin
          state_next = IDLE;
        end else begin
          accept = s_axis_valid;
        end
      end
      default: state_next = IDLE;
    endcase
    done = accept && (count == CNT_LAST);
  end

  // Sum is ACC_W wide, so the Nth sample never overflows; the shifted result always fits in D bits.
  always_comb begin
    result_word = '0;
    for (int k = 0; k < CH; k++) begin
      sample[k] = s_axis_data[k*W +: D];
      sum[k]    = acc[k] + sample[k];
      avg[k]    = D'(sum[k] >>> L);
      result_word[k*W +: W] = {{(W-D){avg[k][D-1]}}, avg[k]};
    end
  end

  assign load = done && (!m_axis_valid || m_axis_ready);
  assign drop = done && m_axis_valid && !m_axis_ready;

  always_ff @(posedge in_adc_clk) begin
    if (in_rst) begin
      state           <= IDLE;
      count           <= '0;
      m_axis_valid    <= 1'b0;
      m_axis_data     <= '0;
      out_overflow    <= 1'b0;
      out_block_count <= '0;
      for (int k = 0; k < CH; k++) begin
        acc[k] <= '0;
      end
    end else begin
      state <= state_next;

      if (!in_enable) begin
        count <= '0;
        for (int k = 0; k < CH; k++) begin
          acc[k] <= '0;
        end
      end else if (accept) begin
        if (done) begin
          count <= '0;
          for (int k = 0; k < CH; k++) begin
            acc[k] <= '0;
          end
        end else begin
          count <= count + CNT_W'(1);
          for (int k = 0; k < CH; k++) begin
            acc[k] <= sum[k];
          end
        end
      end

      if (load) begin
        m_axis_data  <= result_word;
        m_axis_valid <= 1'b1;
      end else if (m_axis_ready) begin
        m_axis_valid <= 1'b0;
      end

      if (m_axis_valid && m_axis_ready) begin
        out_block_count <= out_block_count + 16'd1;
      end

      // A drop in the same cycle as a clear must still leave the flag set.
      if (drop) begin
        out_overflow <= 1'b1;
      end else if (in_clear_overflow) begin
        out_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_adc_decimator.sv
// Scoreboard bench for axis_adc_decimator: one instance at L=2 for averaging, backpressure, enable and reset cases,
// and one at L=0 for back-to-back pass-through.
module tb_axis_adc_decimator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_en, a_clr, a_sv, a_mv, a_mr, a_ovf;
  logic [31:0] a_sd, a_md;
  logic [15:0] a_bc;
  logic        b_en, b_clr, b_sv, b_mv, b_mr, b_ovf;
  logic [31:0] b_sd, b_md;
  logic [15:0] b_bc;

  axis_adc_decimator #(
    .INT_ADC_CHANNELS(2), .INT_ADC_DATA_WIDTH(10),
    .INT_AXIS_DATA_WIDTH(32), .INT_LOG2_DECIMATION(2)
  ) dut_a (
    .in_adc_clk(clk), .in_rst(rst), .in_enable(a_en), .in_clear_overflow(a_clr),
    .s_axis_valid(a_sv), .s_axis_data(a_sd), .m_axis_valid(a_mv), .m_axis_ready(a_mr),
    .m_axis_data(a_md), .out_overflow(a_ovf), .out_block_count(a_bc)
  );

  axis_adc_decimator #(
    .INT_ADC_CHANNELS(2), .INT_ADC_DATA_WIDTH(10),
    .INT_AXIS_DATA_WIDTH(32), .INT_LOG2_DECIMATION(0)
  ) dut_b (
    .in_adc_clk(clk), .in_rst(rst), .in_enable(b_en), .in_clear_overflow(b_clr),
    .s_axis_valid(b_sv), .s_axis_data(b_sd), .m_axis_valid(b_mv), .m_axis_ready(b_mr),
    .m_axis_data(b_md), .out_overflow(b_ovf), .out_block_count(b_bc)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] in_word(input int l0, input int l1, input logic [5:0] pad);
    logic [9:0] s0, s1;
    s0 = 10'(l0);
    s1 = 10'(l1);
    return {pad, s1, pad, s0};
  endfunction

  function automatic logic [31:0] exp_word(input int l0, input int l1);
    logic [15:0] e0, e1;
    e0 = 16'(l0);
    e1 = 16'(l1);
    return {e1, e0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every delivered beat must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && a_mv && a_mr) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_beat: unexpected beat %h", a_md);
      end else begin
        chk("a_beat", a_md, q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_mv && b_mr) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_beat: unexpected beat %h", b_md);
      end else begin
        chk("b_beat", b_md, q_b.pop_front());
      end
    end
  end

  task automatic a_sample(input int l0, input int l1, input logic [5:0] pad);
    a_sv = 1'b1;
    a_sd = in_word(l0, l1, pad);
    tick();
    a_sv = 1'b0;
  endtask

  task automatic a_block(input int v0[4], input int v1[4], input logic [5:0] pad,
                         input logic [31:0] exp, input string name);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q_a.push_back(exp);
      a_sample(v0[i], v1[i], pad);
    end
    chk({name, "_latency"}, {31'd0, a_mv}, 32'd1);
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  int bv0[8] = '{5, -5, 511, -512, 0, 1, -1, 300};
  int bv1[8] = '{-3, 7, -512, 511, 100, -100, 2, -2};

  initial begin
    rst = 1'b1;
    a_en = 0; a_clr = 0; a_sv = 0; a_sd = '0; a_mr = 1;
    b_en = 0; b_clr = 0; b_sv = 0; b_sd = '0; b_mr = 1;
    reset_cycles(2);
    chk("rst_valid", {31'd0, a_mv}, 32'd0);
    chk("rst_data", a_md, 32'd0);
    chk("rst_ovf", {31'd0, a_ovf}, 32'd0);
    chk("rst_count", {16'd0, a_bc}, 32'd0);

    // Averaging with input gaps; enable rises on the same edge as the first sample.
    a_en = 1'b1;
    a_sample(4, 0, 6'd0);
    tick();
    a_sample(8, 0, 6'd0);
    tick(); tick();
    a_sample(12, 0, 6'd0);
    q_a.push_back(32'h0001_000A);
    a_sample(16, 4, 6'd0);
    chk("avg_latency", {31'd0, a_mv}, 32'd1);
    tick(); tick();

    // Floor rounding, padding ones ignored, and range extremes.
    a_block('{-1, -2, -2, -2}, '{3, 3, 3, 3}, 6'h3F, exp_word(-2, 3), "sign");
    a_block('{511, 511, 511, 511}, '{-512, -512, -512, -512}, 6'h3F, exp_word(511, -512), "ext1");
    a_block('{-512, -512, -512, -512}, '{511, 511, 511, 511}, 6'h00, exp_word(-512, 511), "ext2");
    tick();

    // Enable drop discards the partial block.
    for (int i = 0; i < 3; i++) a_sample(7, 7, 6'd0);
    a_en = 1'b0;
    tick(); tick();
    a_en = 1'b1;
    a_block('{100, 100, 100, 100}, '{-100, -100, -100, -100}, 6'd0, exp_word(100, -100), "drop");
    tick(); tick();
    chk("count_after_drop", {16'd0, a_bc}, 32'd5);
    chk("ovf_clean", {31'd0, a_ovf}, 32'd0);

    // Backpressure: first result held, later results dropped.
    reset_cycles(1);
    a_mr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) q_a.push_back(exp_word(10, 20));
      a_sv = 1'b1;
      a_sd = (i < 4) ? in_word(10, 20, 6'd0) : (i < 8) ? in_word(30, 40, 6'd0) : in_word(50, 60, 6'd0);
      tick();
      if (i == 3) chk("bp_first", a_md, exp_word(10, 20));
    end
    a_sv = 1'b0;
    chk("bp_hold_valid", {31'd0, a_mv}, 32'd1);
    chk("bp_hold_data", a_md, exp_word(10, 20));
    chk("bp_ovf_set", {31'd0, a_ovf}, 32'd1);
    a_mr = 1'b1;
    tick();
    chk("bp_drained", {31'd0, a_mv}, 32'd0);
    chk("bp_count", {16'd0, a_bc}, 32'd1);
    tick(); tick();
    chk("bp_count_still", {16'd0, a_bc}, 32'd1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("bp_ovf_clear", {31'd0, a_ovf}, 32'd0);

    // Reset with a result pending and a half-full block.
    a_mr = 1'b0;
    for (int i = 0; i < 4; i++) a_sample(8, -8, 6'd0);
    chk("pend_valid", {31'd0, a_mv}, 32'd1);
    chk("pend_data", a_md, exp_word(8, -8));
    a_sample(1, 1, 6'd0);
    a_sample(1, 1, 6'd0);
    reset_cycles(1);
    chk("mid_rst_valid", {31'd0, a_mv}, 32'd0);
    chk("mid_rst_data", a_md, 32'd0);
    chk("mid_rst_ovf", {31'd0, a_ovf}, 32'd0);
    chk("mid_rst_count", {16'd0, a_bc}, 32'd0);
    a_mr = 1'b1;
    a_block('{1, 2, 3, 5}, '{2, 2, 2, 2}, 6'd0, exp_word(2, 2), "post_rst");
    tick(); tick();
    chk("post_rst_count", {16'd0, a_bc}, 32'd1);

    // L=0: simultaneous consume and load every cycle.
    b_en = 1'b1;
    b_sv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_sd = in_word(bv0[i], bv1[i], (i % 2 == 0) ? 6'h3F : 6'h00);
      q_b.push_back(exp_word(bv0[i], bv1[i]));
      tick();
      chk("b_no_bubble", {31'd0, b_mv}, 32'd1);
    end
    b_sv = 1'b0;
    tick(); tick();
    chk("b_ovf", {31'd0, b_ovf}, 32'd0);
    chk("b_count", {16'd0, b_bc}, 32'd8);

    chk("a_queue_empty", q_a.size(), 32'd0);
    chk("b_queue_empty", q_b.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
